// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   REG_ADDR_W       : register-file address width
//   DRAIN_CYCLES_DEF : default number of cycles needed to empty EX/MEM/WB
//   hdu_state_e      : hazard unit FSM encoding
package pipeline_pkg;

  localparam int REG_ADDR_W       = 5;
  localparam int DRAIN_CYCLES_DEF = 3;

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_DRAIN  = 2'b01,
    ST_HALTED = 2'b10
  } hdu_state_e;

endpackage

// File: rtl/hazard_detection_unit_if.sv
// Signal bundle between the pipeline datapath and the hazard detection unit.
//   master : pipeline side, drives stage information, receives stall/flush
//   slave  : hazard unit side
//   i_enable        debug run/step enable
//   i_instr_rs_D/rt ID source registers
//   i_write_reg_E/M EX/MEM destination registers
//   i_reg_write_E, i_mem_to_reg_E, i_mem_to_reg_M  stage control bits
//   i_branch_D, i_branch_taken_D, i_halt_D          ID decode information
//   o_stall_F/D, o_flush_E/D                         pipeline control
//   o_halted, o_stall_cnt                            debug readout
interface hazard_detection_unit_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
);

  logic                  i_enable;
  logic [REG_ADDR_W-1:0] i_instr_rs_D;
  logic [REG_ADDR_W-1:0] i_instr_rt_D;
  logic [REG_ADDR_W-1:0] i_write_reg_E;
  logic                  i_reg_write_E;
  logic                  i_mem_to_reg_E;
  logic [REG_ADDR_W-1:0] i_write_reg_M;
  logic                  i_mem_to_reg_M;
  logic                  i_branch_D;
  logic                  i_branch_taken_D;
  logic                  i_halt_D;
  logic                  o_stall_F;
  logic                  o_stall_D;
  logic                  o_flush_E;
  logic                  o_flush_D;
  logic                  o_halted;
  logic [CNT_W-1:0]      o_stall_cnt;

  modport master (
    output i_enable, i_instr_rs_D, i_instr_rt_D, i_write_reg_E, i_reg_write_E,
           i_mem_to_reg_E, i_write_reg_M, i_mem_to_reg_M, i_branch_D,
           i_branch_taken_D, i_halt_D,
    input  o_stall_F, o_stall_D, o_flush_E, o_flush_D, o_halted, o_stall_cnt
  );

  modport slave (
    input  i_enable, i_instr_rs_D, i_instr_rt_D, i_write_reg_E, i_reg_write_E,
           i_mem_to_reg_E, i_write_reg_M, i_mem_to_reg_M, i_branch_D,
           i_branch_taken_D, i_halt_D,
    output o_stall_F, o_stall_D, o_flush_E, o_flush_D, o_halted, o_stall_cnt
  );

endinterface

// File: rtl/hazard_compare.sv
// Combinational dependency detection for the instruction in ID.
//   rs, rt          ID source registers
//   write_reg_e/m   EX / MEM destination registers
//   reg_write_e     EX instruction writes the register file
//   mem_to_reg_e/m  EX / MEM instruction is a load
//   branch_d        ID holds a compare-in-ID branch
//   lu              load in EX feeds ID (forwarding cannot help)
//   br              branch compare needs a value not yet available in ID
module hazard_compare #(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [REG_ADDR_W-1:0] rt,
  input  logic [REG_ADDR_W-1:0] write_reg_e,
  input  logic [REG_ADDR_W-1:0] write_reg_m,
  input  logic                  reg_write_e,
  input  logic                  mem_to_reg_e,
  input  logic                  mem_to_reg_m,
  input  logic                  branch_d,
  output logic                  lu,
  output logic                  br
);

  logic e_match;
  logic m_match;

  // $zero is never a real producer, so it can never create a dependency.
  assign e_match = (write_reg_e != '0) && ((write_reg_e == rs) || (write_reg_e == rt));
  assign m_match = (write_reg_m != '0) && ((write_reg_m == rs) || (write_reg_m == rt));

  assign lu = mem_to_reg_e & e_match;
  // The branch comparator sits in ID, so any EX result and a MEM load result
  // arrive too late for it.
  assign br = branch_d & ((reg_write_e & e_match) | (mem_to_reg_m & m_match));

endmodule

// File: rtl/hazard_detection_unit.sv
// Stall/flush controller for the 5-stage pipeline.
//   i_clk   pipeline clock
//   i_reset asynchronous active-low reset
//   bus     slave side of hazard_detection_unit_if (stage info in,
//           stall/flush/halted/stall count out)
// Stall/flush outputs are combinational from the current state and inputs;
// state, drain counter, o_halted and o_stall_cnt advance only when enabled.
//
// state     | meaning
// ST_RUN    | normal operation, hazards resolved by stalling/flushing
// ST_DRAIN  | HALT accepted, letting EX/MEM/WB empty
// ST_HALTED | pipeline empty, frozen until reset
module hazard_detection_unit #(
  parameter int REG_ADDR_W   = pipeline_pkg::REG_ADDR_W,
  parameter int DRAIN_CYCLES = pipeline_pkg::DRAIN_CYCLES_DEF,
  parameter int CNT_W        = 16
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  hazard_detection_unit_if.slave bus
);

  import pipeline_pkg::*;

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  hdu_state_e       state;
  logic [DW-1:0]    drain_cnt;
  logic             halted_q;
  logic [CNT_W-1:0] stall_cnt_q;

  logic lu;
  logic br;
  logic stall;
  logic take_flush;
  logic halt_go;
  logic stall_fd;
  logic flush_e;
  logic flush_d;

  hazard_compare #(.REG_ADDR_W(REG_ADDR_W)) u_compare (
    .rs           (bus.i_instr_rs_D),
    .rt           (bus.i_instr_rt_D),
    .write_reg_e  (bus.i_write_reg_E),
    .write_reg_m  (bus.i_write_reg_M),
    .reg_write_e  (bus.i_reg_write_E),
    .mem_to_reg_e (bus.i_mem_to_reg_E),
    .mem_to_reg_m (bus.i_mem_to_reg_M),
    .branch_d     (bus.i_branch_D),
    .lu           (lu),
    .br           (br)
  );

  assign stall      = lu | br;
  assign take_flush = bus.i_branch_taken_D & bus.i_branch_D;
  // A HALT waiting behind a stall or a squashed slot is not accepted yet.
  assign halt_go    = (state == ST_RUN) && !stall && !take_flush && bus.i_halt_D;

  always_comb begin
    stall_fd = 1'b0;
    flush_e  = 1'b0;
    flush_d  = 1'b0;
    // Gating with reset keeps every output at 0 while reset is held.
    if (i_reset) begin
      case (state)
        ST_DRAIN, ST_HALTED: begin
          stall_fd = 1'b1;
          flush_e  = 1'b1;
        end
        default: begin
          if (stall) begin
            stall_fd = 1'b1;
            flush_e  = 1'b1;
          end else if (take_flush) begin
            flush_d = 1'b1;
          end else if (bus.i_halt_D) begin
            stall_fd = 1'b1;
            flush_e  = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state       <= ST_RUN;
      drain_cnt   <= '0;
      halted_q    <= 1'b0;
      stall_cnt_q <= '0;
    end else if (bus.i_enable) begin
      case (state)
        ST_RUN: begin
          if (stall_fd && !(&stall_cnt_q)) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
          end
          if (halt_go) begin
            state     <= ST_DRAIN;
            drain_cnt <= DW'(DRAIN_CYCLES - 1);
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == '0) begin
            state    <= ST_HALTED;
            halted_q <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - 1'b1;
          end
        end
        ST_HALTED: begin
          halted_q <= 1'b1;
        end
        default: begin
          state    <= ST_RUN;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_stall_F   = stall_fd;
  assign bus.o_stall_D   = stall_fd;
  assign bus.o_flush_E   = flush_e;
  assign bus.o_flush_D   = flush_d;
  assign bus.o_halted    = halted_q;
  assign bus.o_stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_detection_unit.sv
module tb_hazard_detection_unit;

  typedef struct {
    logic stl;
    logic fd;
    logic h;
    int   cnt;
  } exp_t;

  logic clk;
  logic rst_n;
  logic rst_lvl;
  int   checks;
  int   errors;
  int   cyc;
  exp_t sb[$];

  hazard_detection_unit_if #(.REG_ADDR_W(5), .CNT_W(16)) bus ();

  hazard_detection_unit #(.REG_ADDR_W(5), .DRAIN_CYCLES(3), .CNT_W(16)) dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, cyc, act, req);
    end
  endtask

  // Scoreboard monitor: one expected record per presented cycle.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("stall_F", int'(bus.o_stall_F), int'(e.stl));
      chk("stall_D", int'(bus.o_stall_D), int'(e.stl));
      chk("flush_E", int'(bus.o_flush_E), int'(e.stl));
      chk("flush_D", int'(bus.o_flush_D), int'(e.fd));
      chk("halted", int'(bus.o_halted), int'(e.h));
      chk("stall_cnt", int'(bus.o_stall_cnt), e.cnt);
      cyc++;
    end
  end

  // Applies one cycle of inputs just after the rising edge and queues the
  // hand-computed response expected for that cycle.
  task automatic step(input logic en, input logic [4:0] rs, rt, we,
                      input logic rwe, mtre, input logic [4:0] wm,
                      input logic mtrm, brd, tkd, hlt,
                      input logic stl, fd, h, input int cnt);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n                = rst_lvl;
    bus.i_enable         = en;
    bus.i_instr_rs_D     = rs;
    bus.i_instr_rt_D     = rt;
    bus.i_write_reg_E    = we;
    bus.i_reg_write_E    = rwe;
    bus.i_mem_to_reg_E   = mtre;
    bus.i_write_reg_M    = wm;
    bus.i_mem_to_reg_M   = mtrm;
    bus.i_branch_D       = brd;
    bus.i_branch_taken_D = tkd;
    bus.i_halt_D         = hlt;
    e.stl = stl;
    e.fd  = fd;
    e.h   = h;
    e.cnt = cnt;
    sb.push_back(e);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    cyc     = 0;
    rst_n   = 1'b0;
    rst_lvl = 1'b0;
    bus.i_enable = 1'b0; bus.i_instr_rs_D = '0; bus.i_instr_rt_D = '0;
    bus.i_write_reg_E = '0; bus.i_reg_write_E = 1'b0; bus.i_mem_to_reg_E = 1'b0;
    bus.i_write_reg_M = '0; bus.i_mem_to_reg_M = 1'b0; bus.i_branch_D = 1'b0;
    bus.i_branch_taken_D = 1'b0; bus.i_halt_D = 1'b0;

    //   en rs rt we rwe mtre wm mtrm br tk hlt | stl fd h cnt
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0);  // in reset
    rst_lvl = 1'b1;
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0);  // idle
    step(1, 8, 0, 8, 1, 1, 0, 0, 0, 0, 0,   1, 0, 0, 0);  // load-use on rs
    step(1, 8, 0, 0, 0, 0, 8, 1, 0, 0, 0,   0, 0, 0, 1);  // load in MEM, no branch
    step(1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0,   0, 0, 0, 1);  // load to $zero
    step(1, 0, 9, 9, 1, 1, 0, 0, 1, 0, 0,   1, 0, 0, 1);  // branch behind load in EX
    step(1, 0, 9, 0, 0, 0, 9, 1, 1, 0, 0,   1, 0, 0, 2);  // load now in MEM
    step(1, 0, 9, 0, 0, 0, 0, 0, 1, 1, 0,   0, 1, 0, 3);  // taken branch flush
    step(1, 5, 0, 5, 1, 0, 0, 0, 1, 1, 0,   1, 0, 0, 3);  // stall beats taken flush
    step(0, 3, 0, 3, 1, 1, 0, 0, 0, 0, 0,   1, 0, 0, 4);  // frozen, still stalls
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 4);  // count held while frozen
    step(1, 7, 0, 7, 1, 1, 0, 0, 0, 0, 1,   1, 0, 0, 4);  // halt waits behind load-use
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,   1, 0, 0, 5);  // halt accepted (edge t)
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0,   1, 0, 0, 6);  // DRAIN, branch ignored
    for (int i = 0; i < 5; i++)
      step(0, 4, 0, 4, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 6);  // DRAIN frozen
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 6);  // DRAIN
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 6);  // DRAIN last
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0,   1, 0, 1, 6);  // HALTED
    step(1, 2, 0, 2, 1, 1, 0, 0, 0, 0, 1,   1, 0, 1, 6);  // HALTED holds

    // Saturation: push the counter past all-ones.
    rst_lvl = 1'b0;
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0);
    rst_lvl = 1'b1;
    for (int i = 0; i < 65600; i++)
      step(1, 6, 0, 6, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, (i < 65535) ? i : 65535);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,   1, 0, 0, 65535);  // halt
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 65535);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 65535);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 65535);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 1, 65535);  // HALTED, saturated
    rst_lvl = 1'b0;
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0);  // async reset mid-cycle
    rst_lvl = 1'b1;
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0);  // RUN after release
    step(1, 0, 8, 8, 1, 1, 0, 0, 0, 0, 0,   1, 0, 0, 0);  // load-use on rt
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1);

    for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain_scoreboard actual=%0d pending required=0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
